// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types, mode-bit positions and saturating add for the LIF core
// Contents:
//   state_t    - frame FSM states (IDLE, RUN, OUT)
//   OPT_LEAK   - mode bit selecting the v - v/4 leak
//   OPT_SUBRST - mode bit selecting subtractive (vs. zeroing) reset after a spike
//   sat_add    - signed add clamped to a w-bit signed range (w <= 63)
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int OPT_LEAK   = 0;
  localparam int OPT_SUBRST = 1;

  // Operands arrive sign-extended to 64 bits; the sum is formed one bit wider
  // so the clamp decision itself can never overflow.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        w
  );
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sum = {a[63], a} + {b[63], b};
    hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (w - 1));
    if (sum > hi) begin
      sat_add = hi[63:0];
    end else if (sum < lo) begin
      sat_add = lo[63:0];
    end else begin
      sat_add = sum[63:0];
    end
  endfunction

endpackage

// File: rtl/snn_lif_cell.sv
// rtl/snn_lif_cell.sv - one LIF neuron channel: membrane, leak, threshold, reset, spike counter
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - register enable (clock-gate condition from the top)
//   step      - this cycle is an integration beat
//   first     - beat 1 of a frame: membrane prior is 0 and the count restarts
//   leak      - apply v - (v >>> 2) before integrating
//   subrst    - on spike subtract thr instead of clearing to zero
//   cur       - signed input current for this beat
//   thr       - threshold, positive, compared as signed
//   count     - spikes seen so far in the frame
module snn_lif_cell
  import snn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MEM_W  = 20,
  parameter int CNT_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     step,
  input  logic                     first,
  input  logic                     leak,
  input  logic                     subrst,
  input  logic signed [DATA_W-1:0] cur,
  input  logic signed [MEM_W-1:0]  thr,
  output logic        [CNT_W-1:0]  count
);

  logic signed [MEM_W-1:0] v_q;
  logic signed [MEM_W-1:0] v_prior;
  logic signed [MEM_W-1:0] leaked;
  logic signed [MEM_W-1:0] sum;
  logic signed [MEM_W-1:0] v_next;
  logic        [CNT_W-1:0] cnt_base;
  logic                    spike;

  always_comb begin
    v_prior  = first ? '0 : v_q;
    leaked   = leak ? (v_prior - (v_prior >>> 2)) : v_prior;
    sum      = MEM_W'(sat_add(64'(leaked), 64'(cur), MEM_W));
    spike    = (sum >= thr);
    // sum >= thr >= 0 on a spike, so the subtraction cannot underflow.
    v_next   = spike ? (subrst ? (sum - thr) : '0) : sum;
    cnt_base = first ? '0 : count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      count <= '0;
    end else if (en && step) begin
      v_q   <= v_next;
      count <= cnt_base + CNT_W'(spike);
    end
  end

endmodule

// File: rtl/snn_lif_core.sv
// rtl/snn_lif_core.sv - N_CH-channel LIF core: frame FSM, mode latches, serial count output
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   cg_en      - 1: membrane/count registers only enabled on integration beats
//   in_valid   - input beat valid
//   in_data    - N_CH signed currents, channel k at [k*DATA_W +: DATA_W]
//   Opt        - mode (bit0 leak, bit1 subtractive reset), taken on beat 1
//   thr        - positive threshold, taken on beat 1
//   out_valid  - high for N_CH cycles after the last beat of a frame
//   out        - spike count of channel k on the k-th valid cycle, else 0
module snn_lif_core
  import snn_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 16,
  parameter int MEM_W   = 20,
  parameter int T_STEPS = 8,
  parameter int OUT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cg_en,
  input  logic                     in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [1:0]               Opt,
  input  logic [MEM_W-1:0]         thr,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out
);

  localparam int CNT_W  = $clog2(T_STEPS + 1);
  localparam int STEP_W = $clog2(T_STEPS + 1);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [STEP_W-1:0] step_q;
  logic [CH_W-1:0]   ch_q;
  logic [1:0]        opt_q;
  logic [MEM_W-1:0]  thr_q;

  logic              beat_first;
  logic              beat_run;
  logic              step;
  logic              last_beat;
  logic              last_ch;
  logic              cell_en;
  logic [1:0]        opt_eff;
  logic [MEM_W-1:0]  thr_eff;
  logic [CNT_W-1:0]  counts [N_CH];

  always_comb begin
    beat_first = (state_q == IDLE) && in_valid;
    beat_run   = (state_q == RUN) && in_valid;
    step       = beat_first || beat_run;
    // step_q holds beats already taken in this frame.
    if (beat_first) begin
      last_beat = (T_STEPS == 1);
    end else begin
      last_beat = beat_run && (step_q == STEP_W'(T_STEPS - 1));
    end
    last_ch = (ch_q == CH_W'(N_CH - 1));
    // Beat 1 must use the incoming mode/threshold, not the previous frame's latch.
    opt_eff = beat_first ? Opt : opt_q;
    thr_eff = beat_first ? thr : thr_q;
    cell_en = !cg_en || step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (beat_first) state_d = last_beat ? OUT : RUN;
      RUN:  if (last_beat) state_d = OUT;
      OUT:  if (last_ch) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
      ch_q   <= '0;
      opt_q  <= '0;
      thr_q  <= '0;
    end else begin
      if (step) begin
        step_q <= last_beat ? '0 : step_q + 1'b1;
      end
      if (state_q == OUT) begin
        ch_q <= last_ch ? '0 : ch_q + 1'b1;
      end
      if (beat_first) begin
        opt_q <= Opt;
        thr_q <= thr;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cell
    snn_lif_cell #(
      .DATA_W(DATA_W),
      .MEM_W (MEM_W),
      .CNT_W (CNT_W)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .en    (cell_en),
      .step  (step),
      .first (beat_first),
      .leak  (opt_eff[OPT_LEAK]),
      .subrst(opt_eff[OPT_SUBRST]),
      .cur   ($signed(in_data[g*DATA_W +: DATA_W])),
      .thr   ($signed(thr_eff)),
      .count (counts[g])
    );
  end

  always_comb begin
    out_valid = (state_q == OUT);
    out       = out_valid ? OUT_W'(counts[ch_q]) : '0;
  end

endmodule

// File: tb/tb_snn_lif_core.sv
// tb/tb_snn_lif_core.sv - self-checking bench: directed and random frames, reset abort, gated vs ungated
module tb_snn_lif_core;

  localparam int N_CH    = 4;
  localparam int DATA_W  = 16;
  localparam int MEM_W   = 18;
  localparam int T_STEPS = 8;
  localparam int OUT_W   = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cg_a = 1'b0;
  logic                   cg_b = 1'b1;
  logic                   in_valid;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [1:0]             opt_in;
  logic [MEM_W-1:0]       thr_in;
  logic                   ov_a, ov_b;
  logic [OUT_W-1:0]       out_a, out_b;

  int total = 0;
  int bad   = 0;

  int          cur [T_STEPS][N_CH];
  logic [1:0]  fopt;
  longint      fthr;
  int          expc [N_CH];

  always #5 clk = ~clk;

  snn_lif_core #(.N_CH(N_CH), .DATA_W(DATA_W), .MEM_W(MEM_W), .T_STEPS(T_STEPS), .OUT_W(OUT_W)) dut_a (
    .clk(clk), .rst(rst), .cg_en(cg_a), .in_valid(in_valid), .in_data(in_data),
    .Opt(opt_in), .thr(thr_in), .out_valid(ov_a), .out(out_a)
  );

  snn_lif_core #(.N_CH(N_CH), .DATA_W(DATA_W), .MEM_W(MEM_W), .T_STEPS(T_STEPS), .OUT_W(OUT_W)) dut_b (
    .clk(clk), .rst(rst), .cg_en(cg_b), .in_valid(in_valid), .in_data(in_data),
    .Opt(opt_in), .thr(thr_in), .out_valid(ov_b), .out(out_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Gated and ungated cores see identical stimulus and must match every cycle.
  always @(negedge clk) begin
    chk("cg_out_valid", 64'(ov_b), 64'(ov_a));
    chk("cg_out", 64'(out_b), 64'(out_a));
  end

  // Reference: plain integer LIF over the whole frame.
  task automatic model();
    longint hi = (64'sd1 <<< (MEM_W - 1)) - 1;
    longint lo = -hi - 1;
    for (int ch = 0; ch < N_CH; ch++) begin
      longint v = 0;
      longint s;
      int c = 0;
      for (int t = 0; t < T_STEPS; t++) begin
        if (fopt[0]) v = v - (v >>> 2);
        s = v + longint'(cur[t][ch]);
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        if (s >= fthr) begin
          c++;
          v = fopt[1] ? (s - fthr) : 0;
        end else begin
          v = s;
        end
      end
      expc[ch] = c;
    end
  endtask

  task automatic set_idle();
    in_valid = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) in_data[ch*DATA_W +: DATA_W] = DATA_W'($urandom);
    opt_in = 2'($urandom);
    thr_in = MEM_W'($urandom);
  endtask

  // Beats after the first carry junk Opt/thr: the core must hold its beat-1 latch.
  task automatic set_beat(input int t);
    in_valid = 1'b1;
    for (int ch = 0; ch < N_CH; ch++) in_data[ch*DATA_W +: DATA_W] = DATA_W'(cur[t][ch]);
    opt_in = (t == 0) ? fopt : 2'($urandom);
    thr_in = (t == 0) ? MEM_W'(fthr) : MEM_W'($urandom);
  endtask

  task automatic drive_beats(input int first, input int last, input bit gaps);
    for (int t = first; t <= last; t++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk("gap_out_valid", 64'(ov_a), 64'd0);
          set_idle();
        end
      end
      @(negedge clk);
      chk("beat_out_valid", 64'(ov_a), 64'd0);
      set_beat(t);
    end
  endtask

  task automatic collect(input int n, input bit noise);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("out_valid_ch%0d", k), 64'(ov_a), 64'd1);
      chk($sformatf("out_ch%0d", k), 64'(out_a), 64'(expc[k]));
      if (noise) set_beat(int'($urandom_range(0, T_STEPS - 1)));
      else set_idle();
    end
  endtask

  task automatic finish_frame();
    @(negedge clk);
    chk("after_out_valid", 64'(ov_a), 64'd0);
    chk("after_out", 64'(out_a), 64'd0);
    set_idle();
  endtask

  task automatic const_frame(input int i0, input int i1, input int i2, input int i3,
                             input logic [1:0] o, input longint th);
    for (int t = 0; t < T_STEPS; t++) begin
      cur[t][0] = i0; cur[t][1] = i1; cur[t][2] = i2; cur[t][3] = i3;
    end
    fopt = o;
    fthr = th;
  endtask

  task automatic rand_frame();
    logic signed [DATA_W-1:0] r;
    for (int t = 0; t < T_STEPS; t++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(0, 1) == 1) r = DATA_W'($urandom);
        else r = DATA_W'(int'($urandom_range(0, 400)) - 150);
        cur[t][ch] = int'(r);
      end
    end
    fopt = 2'($urandom);
    case ($urandom_range(0, 3))
      0:       fthr = 0;
      1:       fthr = 131071;
      default: fthr = longint'($urandom_range(1, 70000));
    endcase
    model();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(ov_a), 64'd0);
    chk("reset_out", 64'(out_a), 64'd0);
    rst = 1'b0;

    // Defaults: thr=100, no leak, zeroing reset.
    const_frame(60, 0, 100, -50, 2'b00, 100);
    expc = '{4, 0, 8, 0};
    drive_beats(0, T_STEPS - 1, 1'b0);
    collect(N_CH, 1'b0);
    finish_frame();

    // Reset-mode contrast, I=70.
    const_frame(70, 70, 70, 70, 2'b00, 100);
    expc = '{4, 4, 4, 4};
    drive_beats(0, T_STEPS - 1, 1'b0);
    collect(N_CH, 1'b0);
    finish_frame();

    const_frame(70, 70, 70, 70, 2'b10, 100);
    expc = '{5, 5, 5, 5};
    drive_beats(0, T_STEPS - 1, 1'b0);
    collect(N_CH, 1'b0);
    finish_frame();

    // Leak: 40,70,93,110->0 repeating.
    const_frame(40, 40, 40, 40, 2'b01, 100);
    expc = '{2, 2, 2, 2};
    drive_beats(0, T_STEPS - 1, 1'b0);
    collect(N_CH, 1'b0);
    finish_frame();

    // Saturation at the top of the 18-bit range; negative rail on ch3.
    const_frame(32767, 32767, 32767, -32768, 2'b00, 131071);
    expc = '{1, 1, 1, 0};
    drive_beats(0, T_STEPS - 1, 1'b0);
    collect(N_CH, 1'b0);
    finish_frame();

    // Random back-to-back frames with gaps and in_valid during OUT.
    for (int f = 0; f < 8; f++) begin
      rand_frame();
      drive_beats(0, T_STEPS - 1, 1'b1);
      collect(N_CH, 1'b1);
    end
    finish_frame();

    // Reset mid-frame.
    rand_frame();
    drive_beats(0, 2, 1'b0);
    #2 rst = 1'b1;
    set_idle();
    #1;
    chk("rst_mid_frame_out_valid", 64'(ov_a), 64'd0);
    chk("rst_mid_frame_out", 64'(out_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-output.
    rand_frame();
    drive_beats(0, T_STEPS - 1, 1'b0);
    collect(2, 1'b0);
    #2 rst = 1'b1;
    set_idle();
    #1;
    chk("rst_mid_out_out_valid", 64'(ov_a), 64'd0);
    chk("rst_mid_out_out", 64'(out_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // After reset a partial frame yields nothing; the 8th beat completes it.
    rand_frame();
    drive_beats(0, T_STEPS - 2, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("partial_out_valid", 64'(ov_a), 64'd0);
      set_idle();
    end
    drive_beats(T_STEPS - 1, T_STEPS - 1, 1'b0);
    collect(N_CH, 1'b0);
    finish_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_lif_core.md
Name: snn_lif_core

Overview:
Parametrised leaky-integrate-and-fire (LIF) neuron core for the SNN datapath. It is the channel-, width- and timestep-generalised successor of the fixed single-frame SNN engine.
- Accepts one frame of T_STEPS input-current beats, N_CH channels in parallel.
- Integrates each channel's membrane with selectable leak and reset modes.
- Counts spikes per channel and serialises the N_CH counts on out.
- Supports optional clock gating via cg_en. Gating has no functional effect.

Parameters:
N_CH, 4, number of parallel neuron channels (>=1)
DATA_W, 16, signed input-current width per channel
MEM_W, 20, signed membrane width (>DATA_W)
T_STEPS, 8, timesteps (beats) per frame (>=1)
OUT_W, 32, output word width (>=clog2(T_STEPS+1))

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
cg_en  in  1  1 = gate membrane/count register enables when idle
in_valid  in  1  beat valid
in_data  in  N_CH*DATA_W  signed currents; channel k at bits [k*DATA_W +: DATA_W]
Opt  in  2  mode; sampled on first beat of a frame
thr  in  MEM_W  unsigned-positive threshold; sampled on first beat
out_valid  out  1  serial count valid
out  out  OUT_W  spike count of current channel, zero-extended

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, out=0, step and channel counters=0, membranes=0, counts=0. Reset asserted mid-frame or mid-output aborts immediately. No output follows until a new full frame is received.
- FSM states: IDLE, RUN, OUT.
  - IDLE->RUN on in_valid. This is beat 1: latch Opt and thr, treat the membrane prior as 0, clear counts.
  - RUN: each in_valid cycle is one step; the step counter advances only on in_valid. Gaps (in_valid=0) pause integration with state held. On beat T_STEPS, go RUN->OUT.
  - OUT: N_CH cycles with out_valid=1; out = count[k], k = 0..N_CH-1 in order. After the last channel, return to IDLE.
  - in_valid during OUT is ignored. A new frame may begin in the first cycle after the last out_valid.
- Latency: the last beat is sampled at edge t. out_valid=1 from cycle t+1 through t+N_CH. out=0 whenever out_valid=0.
- Per-channel step update, in order:
  - Opt[0]=0: no leak, L=v. Opt[0]=1: L = v - (v>>>2), arithmetic shift.
  - s = sat(L + sext(I)), saturating to the signed MEM_W range.
  - spike = (s >= thr), signed compare with thr positive.
  - On spike, Opt[1]=0 resets to zero: v'=0. Opt[1]=1 subtracts: v' = s - thr.
  - No spike: v'=s.
  - count += spike.
- Counts never exceed T_STEPS. No wrap is possible by the width rule.
- thr=0: every step spikes unless s<0.
- Clock gating: with cg_en=1, membrane/count registers are enabled only on RUN&in_valid, on beat 1, or on reset. FSM and output registers are never gated. Outputs are cycle-identical for cg_en=0/1.
- Opt=2'b11 is legal: leak plus subtractive reset.

Decomposition:
- snn_pkg holds:
  - the state enum (IDLE/RUN/OUT);
  - Opt bit constants OPT_LEAK=0 and OPT_SUBRST=1;
  - a saturating-add function parametrised by width.
- Sub-module snn_lif_cell: one channel's membrane, leak, threshold, reset and counter, with enable input. Instantiate it N_CH times in a generate loop. The top level holds the FSM, step/channel counters, Opt/thr latches and the output mux.

Test Plan:
1. Reset: assert rst mid-frame -> out_valid=0 and out=0 asynchronously. After release, no output appears until a full 8-beat frame arrives.
2. Defaults, thr=100, Opt=00, constant I={ch0:60, ch1:0, ch2:100, ch3:-50} for 8 beats -> out=4,0,8,0 on 4 consecutive cycles starting the cycle after the last beat.
3. Reset-mode contrast, I=70 all channels, thr=100: Opt=00 -> every count=4. Opt=10 -> every count=5 (spikes at steps 2,3,5,6,8; v ends at 60).
4. Leak, Opt=01, I=40, thr=100 -> trajectory 40,70,93,110(spike->0) repeated -> count=2.
5. Saturation, MEM_W=18, thr=131071, Opt=00, I=32767 -> step 5 saturates to 131071 and spikes -> count=1. No wrap to negative.
6. Random in_valid gaps inside the frame, in_valid asserted during OUT, back-to-back frames, and the whole test run with cg_en=0 and cg_en=1 -> identical out/out_valid traces. OUT-phase beats are ignored. Each frame yields exactly N_CH outputs.
